lfsr_seg_display: RTL and testbench
===================================

Name: lfsr_seg_display

Overview:
Parametrised successor to the button-stepped shift-register display. It provides a configurable-width Fibonacci LFSR that advances on a debounced button press or by free-running. It supports a synchronous load of a user value, keeps a step counter, and decodes the register into NUM_DIGITS active-low seven-segment digits. It sits between the board I/O (button, switches) and the segment display outputs.

Parameters:
WIDTH, 8, LFSR width in bits; multiple of 4, range 4..4*NUM_DIGITS.
NUM_DIGITS, 8, number of seven-segment digits driven.
TAPS, 8'h1D, feedback mask of WIDTH bits; bit i set means state[i] is XORed into the feedback.
SEED, 8'h01, non-zero WIDTH-bit reset/fallback state.
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a button level change (>=1).
RUN_DIV, 1000, clock cycles per step in free-run mode (>=1).

Ports:
clk  in  1  system clock.
rst  in  1  reset.
button  in  1  raw, asynchronous push button.
run  in  1  1 = free-run stepping; 0 = button stepping.
load  in  1  synchronous load strobe.
load_value  in  WIDTH  value applied on load.
lfsr_out  out  WIDTH  current LFSR state.
step_count  out  16  number of steps taken; wraps modulo 2^16.
seg_out  out  8*NUM_DIGITS  digit i occupies bits [8i+7:8i]; active-low, bit7=a … bit1=g, bit0=dp.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - lfsr_out = SEED; step_count = 0.
  - Synchroniser, debounce counter, debounced level and divider counter all = 0.
  - seg_out reflects SEED immediately.
- Button path:
  - 2-FF synchroniser, then debounce.
  - Debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing sample clears the counter.
  - Debounced 0->1 edge produces a one-cycle step pulse. Release produces nothing.
- Free-run path:
  - Divider counts 0..RUN_DIV-1 while run=1; step pulse on the cycle the count equals RUN_DIV-1, then the count wraps to 0.
  - Divider is held at 0 while run=0.
- Step source: run=1 uses the divider pulse only (button pulses ignored); run=0 uses the button pulse only.
- Step operation (next edge after the pulse):
  - fb = XOR of (state & TAPS).
  - state <= {fb, state[WIDTH-1:1]}.
  - step_count <= step_count + 1.
- Load:
  - load=1: state <= load_value, or SEED if load_value == 0 (prevents lock-up); step_count <= 0.
  - load has priority over a simultaneous step; that step is discarded.
- Display:
  - seg_out is combinational from lfsr_out, with 0 cycles of latency.
  - Digit i (i < WIDTH/4) shows nibble state[4i+3:4i].
  - Digits i >= WIDTH/4 are blank: 8'hFF.
  - dp is always off (1).
- Active-high segment patterns before inversion:
  - 0 FC, 1 60, 2 DA, 3 F2, 4 66, 5 B6, 6 BE, 7 E0
  - 8 FE, 9 F6, A EE, b 3E, C 9C, d 7A, E 9E, F 8E
- Mid-operation events:
  - run toggling mid-count: the divider restarts from 0 and no spurious pulse is generated.
  - rst asserted at any time returns everything to the reset values asynchronously.
- Bounce: button bounces shorter than DEBOUNCE_CYCLES cause no step.

Test Plan:
1. Reset, defaults (W=8, taps 1D, seed 01) -> lfsr_out=8'h01; seg_out digit0=8'h9F, digit1=8'h03, digits2..7=8'hFF; step_count=0.
2. Clean button press held for 20 cycles, then released, four times -> lfsr_out sequence 80, 40, 20, 10; a fifth press gives 88; step_count=5; digit1 for 80 = 8'h01.
3. Button bounce of 5-cycle pulses for 40 cycles, then low -> no step; lfsr_out unchanged, step_count unchanged.
4. run=1, RUN_DIV=4 for 16 cycles from seed 01 -> exactly 4 steps, ending at 8'h10; holding button pressed has no extra effect.
5. load with load_value=8'hA5 coincident with a step pulse -> lfsr_out=A5, step_count=0, digits show 5 (8'h49) and A (8'h11); load_value=0 -> lfsr_out=01.
6. rst asserted mid-debounce and mid-divider, deasserted -> immediate return to SEED/0; the first step requires a full DEBOUNCE_CYCLES press or a full RUN_DIV count.

Source files
------------

// File: rtl/lfsr_seg_display.sv
// Button- or timer-stepped Fibonacci LFSR with synchronous load, step counter
// and an active-low seven-segment decode of the register, one nibble per digit.
module lfsr_seg_display #(
   parameter int unsigned       WIDTH           = 8,
   parameter int unsigned       NUM_DIGITS      = 8,
   parameter logic [WIDTH-1:0]  TAPS            = 8'h1D,
   parameter logic [WIDTH-1:0]  SEED            = 8'h01,
   parameter int unsigned       DEBOUNCE_CYCLES = 16,
   parameter int unsigned       RUN_DIV         = 1000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    button,
   input  logic                    run,
   input  logic                    load,
   input  logic [WIDTH-1:0]        load_value,
   output logic [WIDTH-1:0]        lfsr_out,
   output logic [15:0]             step_count,
   output logic [8*NUM_DIGITS-1:0] seg_out
);

   localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
   localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RUN_DIV - 1);
   localparam int unsigned SHOWN = WIDTH / 4;

   logic             btn_meta;
   logic             btn_sync;
   logic [DB_W-1:0]  db_cnt;
   logic             db_level;
   logic             btn_pulse;
   logic [DIV_W-1:0] div_cnt;
   logic             div_pulse;
   logic             step;
   logic [WIDTH-1:0] state;
   logic [15:0]      steps;
   logic             fb;
   logic [WIDTH-1:0] shifted;

   // Synchroniser plus debouncer; the step pulse is registered on the accepted press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_meta  <= 1'b0;
         btn_sync  <= 1'b0;
         db_cnt    <= '0;
         db_level  <= 1'b0;
         btn_pulse <= 1'b0;
      end else begin
         btn_meta  <= button;
         btn_sync  <= btn_meta;
         btn_pulse <= 1'b0;
         if (btn_sync == db_level) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_MAX) begin
            db_cnt    <= '0;
            db_level  <= btn_sync;
            btn_pulse <= btn_sync;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (!run || div_cnt == DIV_MAX) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   always_comb begin
      div_pulse = run && (div_cnt == DIV_MAX);
      step      = run ? div_pulse : btn_pulse;
      fb        = ^(state & TAPS);
      shifted   = {fb, state[WIDTH-1:1]};
   end

   // Load wins over a coincident step; a zero load would lock the LFSR, so SEED is used.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= SEED;
         steps <= '0;
      end else if (load) begin
         state <= (load_value == '0) ? SEED : load_value;
         steps <= '0;
      end else if (step) begin
         state <= shifted;
         steps <= steps + 16'd1;
      end
   end

   function automatic logic [7:0] seg_pattern(input logic [3:0] nib);
      logic [7:0] p;
      case (nib)
         4'h0: p = 8'hFC;
         4'h1: p = 8'h60;
         4'h2: p = 8'hDA;
         4'h3: p = 8'hF2;
         4'h4: p = 8'h66;
         4'h5: p = 8'hB6;
         4'h6: p = 8'hBE;
         4'h7: p = 8'hE0;
         4'h8: p = 8'hFE;
         4'h9: p = 8'hF6;
         4'hA: p = 8'hEE;
         4'hB: p = 8'h3E;
         4'hC: p = 8'h9C;
         4'hD: p = 8'h7A;
         4'hE: p = 8'h9E;
         default: p = 8'h8E;
      endcase
      return p;
   endfunction

   always_comb begin
      seg_out = '1;
      for (int unsigned i = 0; i < SHOWN; i++) begin
         seg_out[8*i +: 8] = ~seg_pattern(state[4*i +: 4]);
      end
   end

   assign lfsr_out   = state;
   assign step_count = steps;

endmodule

// File: tb/tb_lfsr_seg_display.sv
// Table-driven bench for lfsr_seg_display; a negedge monitor pops expected
// register/counter values from a scoreboard queue every time the DUT state moves.
module tb_lfsr_seg_display;

   localparam int unsigned RUN_DIV = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        button = 1'b0;
   logic        run = 1'b0;
   logic        load = 1'b0;
   logic [7:0]  load_value = '0;
   logic [7:0]  lfsr_out;
   logic [15:0] step_count;
   logic [63:0] seg_out;

   lfsr_seg_display #(
      .WIDTH(8),
      .NUM_DIGITS(8),
      .TAPS(8'h1D),
      .SEED(8'h01),
      .DEBOUNCE_CYCLES(16),
      .RUN_DIV(RUN_DIV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .button(button),
      .run(run),
      .load(load),
      .load_value(load_value),
      .lfsr_out(lfsr_out),
      .step_count(step_count),
      .seg_out(seg_out)
   );

   always #5 clk = ~clk;

   typedef enum {OP_RESET, OP_PRESS, OP_BOUNCE, OP_LOAD, OP_RUN, OP_LDSTEP} op_e;
   typedef struct {
      op_e         op;
      logic [7:0]  val;
      int unsigned hold;
      logic [7:0]  exp_lfsr;
      logic [15:0] exp_cnt;
      logic [63:0] exp_seg;
   } vec_t;
   typedef struct {
      logic [7:0]  lfsr;
      logic [15:0] cnt;
   } exp_t;

   vec_t        vecs[14];
   exp_t        exp_q[$];
   int unsigned n_vec = 0;
   int unsigned n_fail = 0;
   logic [7:0]  m_lfsr = 8'h01;
   logic [15:0] m_cnt = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step_cycles(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] model_next(input logic [7:0] s);
      return {^(s & 8'h1D), s[7:1]};
   endfunction

   task automatic push_step();
      m_lfsr = model_next(m_lfsr);
      m_cnt  = m_cnt + 16'd1;
      exp_q.push_back('{m_lfsr, m_cnt});
   endtask

   task automatic push_load(input logic [7:0] v);
      m_lfsr = (v == 8'h00) ? 8'h01 : v;
      m_cnt  = '0;
      exp_q.push_back('{m_lfsr, m_cnt});
   endtask

   task automatic do_load(input logic [7:0] v);
      push_load(v);
      load       = 1'b1;
      load_value = v;
      step_cycles(1);
      load = 1'b0;
      step_cycles(2);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got running, expected done");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0]  prev_l;
      logic [15:0] prev_c;
      exp_t        e;

      vecs[0]  = '{OP_RESET,  8'h00, 0,  8'h01, 16'd0,  64'hFFFF_FFFF_FFFF_039F};
      vecs[1]  = '{OP_PRESS,  8'h00, 0,  8'h80, 16'd1,  64'hFFFF_FFFF_FFFF_0103};
      vecs[2]  = '{OP_PRESS,  8'h00, 0,  8'h40, 16'd2,  64'hFFFF_FFFF_FFFF_9903};
      vecs[3]  = '{OP_PRESS,  8'h00, 0,  8'h20, 16'd3,  64'hFFFF_FFFF_FFFF_2503};
      vecs[4]  = '{OP_PRESS,  8'h00, 0,  8'h10, 16'd4,  64'hFFFF_FFFF_FFFF_9F03};
      vecs[5]  = '{OP_PRESS,  8'h00, 0,  8'h88, 16'd5,  64'hFFFF_FFFF_FFFF_0101};
      vecs[6]  = '{OP_BOUNCE, 8'h00, 0,  8'h88, 16'd5,  64'hFFFF_FFFF_FFFF_0101};
      vecs[7]  = '{OP_LOAD,   8'h00, 0,  8'h01, 16'd0,  64'hFFFF_FFFF_FFFF_039F};
      vecs[8]  = '{OP_RUN,    8'h00, 16, 8'h10, 16'd4,  64'hFFFF_FFFF_FFFF_9F03};
      vecs[9]  = '{OP_RUN,    8'h00, 3,  8'h10, 16'd4,  64'hFFFF_FFFF_FFFF_9F03};
      vecs[10] = '{OP_RUN,    8'h00, 3,  8'h10, 16'd4,  64'hFFFF_FFFF_FFFF_9F03};
      vecs[11] = '{OP_RUN,    8'h01, 24, 8'h1C, 16'd10, 64'hFFFF_FFFF_FFFF_9F63};
      vecs[12] = '{OP_LDSTEP, 8'hA5, 0,  8'hA5, 16'd0,  64'hFFFF_FFFF_FFFF_1149};
      vecs[13] = '{OP_LOAD,   8'h00, 0,  8'h01, 16'd0,  64'hFFFF_FFFF_FFFF_039F};

      prev_l = '0;
      prev_c = '0;
      fork
         forever begin
            @(negedge clk);
            if (rst) begin
               prev_l = lfsr_out;
               prev_c = step_count;
            end else if (lfsr_out !== prev_l || step_count !== prev_c) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_fail++;
                  $display("FAIL unexpected_step: got lfsr %h count %0d, expected no change from %h",
                           lfsr_out, step_count, prev_l);
               end else begin
                  e = exp_q.pop_front();
                  check("sb_lfsr", {56'd0, lfsr_out}, {56'd0, e.lfsr});
                  check("sb_count", {48'd0, step_count}, {48'd0, e.cnt});
               end
               prev_l = lfsr_out;
               prev_c = step_count;
            end
         end
      join_none

      for (int unsigned v = 0; v < 14; v++) begin
         case (vecs[v].op)
            OP_RESET: begin
               rst = 1'b1;
               step_cycles(3);
               rst    = 1'b0;
               m_lfsr = 8'h01;
               m_cnt  = '0;
               step_cycles(2);
            end
            OP_PRESS: begin
               push_step();
               button = 1'b1;
               step_cycles(20);
               button = 1'b0;
               step_cycles(25);
            end
            OP_BOUNCE: begin
               for (int unsigned k = 0; k < 4; k++) begin
                  button = 1'b1;
                  step_cycles(5);
                  button = 1'b0;
                  step_cycles(5);
               end
               step_cycles(25);
            end
            OP_LOAD: do_load(vecs[v].val);
            OP_RUN: begin
               for (int unsigned k = 0; k < vecs[v].hold / RUN_DIV; k++) push_step();
               run    = 1'b1;
               button = vecs[v].val[0];
               step_cycles(vecs[v].hold);
               run    = 1'b0;
               button = 1'b0;
               step_cycles(25);
            end
            default: begin
               // load asserted on the cycle the divider reaches its terminal count
               run = 1'b1;
               step_cycles(3);
               push_load(vecs[v].val);
               load       = 1'b1;
               load_value = vecs[v].val;
               step_cycles(1);
               load = 1'b0;
               run  = 1'b0;
               step_cycles(10);
            end
         endcase
         check($sformatf("vec%0d_lfsr", v), {56'd0, lfsr_out}, {56'd0, vecs[v].exp_lfsr});
         check($sformatf("vec%0d_count", v), {48'd0, step_count}, {48'd0, vecs[v].exp_cnt});
         check($sformatf("vec%0d_seg", v), seg_out, vecs[v].exp_seg);
      end

      // reset during an incomplete debounce: a fresh full press is needed afterwards
      do_load(8'h5A);
      button = 1'b1;
      step_cycles(10);
      rst = 1'b1;
      #1;
      check("rst_async_lfsr", {56'd0, lfsr_out}, 64'h01);
      check("rst_async_count", {48'd0, step_count}, 64'd0);
      check("rst_async_seg", seg_out, 64'hFFFF_FFFF_FFFF_039F);
      m_lfsr = 8'h01;
      m_cnt  = '0;
      step_cycles(2);
      rst = 1'b0;
      push_step();
      step_cycles(18);
      check("db_no_early_step", {56'd0, lfsr_out}, 64'h01);
      step_cycles(1);
      check("db_first_step_lfsr", {56'd0, lfsr_out}, 64'h80);
      check("db_first_step_count", {48'd0, step_count}, 64'd1);
      button = 1'b0;
      step_cycles(25);

      // reset in the middle of a divider count
      run = 1'b1;
      step_cycles(2);
      rst = 1'b1;
      #1;
      check("rst_div_lfsr", {56'd0, lfsr_out}, 64'h01);
      check("rst_div_count", {48'd0, step_count}, 64'd0);
      m_lfsr = 8'h01;
      m_cnt  = '0;
      step_cycles(2);
      rst = 1'b0;
      push_step();
      step_cycles(3);
      check("div_no_early_step", {56'd0, lfsr_out}, 64'h01);
      step_cycles(1);
      check("div_first_step_lfsr", {56'd0, lfsr_out}, 64'h80);
      check("div_first_step_count", {48'd0, step_count}, 64'd1);
      run = 1'b0;
      step_cycles(5);

      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
